pipelined_datapath: RTL and testbench

- Parametrised three-stage successor to the single-cycle register-file/ALU datapath: operand read, execute, then a held output/writeback stage.
- Operations enter through a valid/ready handshake and leave through a valid/ready handshake.
- Internal forwarding lets back-to-back dependent operations issue without stalls.
- Sits between the control FSM and the register file; owns the register array and the processor status register (PSR) flags.

---
 rtl/pipelined_datapath.sv | 227 ++++++++++++++++++++++
 tb/tb_pipelined_datapath.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_datapath.sv
// pipelined_datapath
//   Three-stage register-file/ALU datapath:
//     S0: operand read from the register array with forwarding (accept cycle)
//     S1: execute (ALU is combinational on the S1 operand registers)
//     S2: held output register; writeback to registers/PSR at output handshake
//   A stall (S2 full and not draining) freezes every stage.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid / in_ready    operation handshake
//   alucont                opcode (0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT,6 LSH,7 RSH,8 MOV,9 CMP,10-15 MOV)
//   ra1, ra2, wa           source A, source B, destination register
//   imm, use_imm           immediate operand and B-select
//   regwrite, set_flags    writeback controls
//   out_valid / out_ready  result handshake
//   result                 completed result (held in S2)
//   psr_flags              {C, L, F, Z, N}
//
// Build option: define ZERO_REG_EN to make register 0 read as zero, discard
// writes to it and exclude it from forwarding.

module pipelined_datapath #(
   parameter int WIDTH   = 16,
   parameter int REGBITS = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alucont,
   input  logic [REGBITS-1:0] ra1,
   input  logic [REGBITS-1:0] ra2,
   input  logic [REGBITS-1:0] wa,
   input  logic [WIDTH-1:0]   imm,
   input  logic               use_imm,
   input  logic               regwrite,
   input  logic               set_flags,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic [4:0]         psr_flags
);

   localparam int NREGS = 2 ** REGBITS;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_LSH = 4'd6;
   localparam logic [3:0] OP_RSH = 4'd7;
   localparam logic [3:0] OP_CMP = 4'd9;

   logic [WIDTH-1:0]   r_regs [NREGS];
   logic [4:0]         r_psr;

   logic               r_s1_valid;
   logic [WIDTH-1:0]   r_s1_a;
   logic [WIDTH-1:0]   r_s1_b;
   logic [3:0]         r_s1_op;
   logic [REGBITS-1:0] r_s1_wa;
   logic               r_s1_wr;
   logic               r_s1_setf;

   logic               r_s2_valid;
   logic [WIDTH-1:0]   r_s2_result;
   logic [4:0]         r_s2_flags;
   logic [REGBITS-1:0] r_s2_wa;
   logic               r_s2_wr;
   logic               r_s2_setf;

   logic               w_advance;
   logic               w_accept;
   logic               w_out_hs;
   logic               w_new_wr;
   logic [WIDTH-1:0]   w_rf_a;
   logic [WIDTH-1:0]   w_rf_b;
   logic [WIDTH-1:0]   w_opnd_a;
   logic [WIDTH-1:0]   w_opnd_b;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_alu_res;
   logic [4:0]         w_alu_flags;

   // The whole pipeline moves only when S2 is empty or being drained.
   assign w_advance = !(r_s2_valid && !out_ready);
   assign w_accept  = in_valid && w_advance;
   assign w_out_hs  = r_s2_valid && out_ready;

   assign in_ready  = w_advance;
   assign out_valid = r_s2_valid;
   assign result    = r_s2_result;
   assign psr_flags = r_psr;

   // CMP is folded into the write enable here so it neither writes nor forwards.
`ifdef ZERO_REG_EN
   assign w_rf_a   = (ra1 == {REGBITS{1'b0}}) ? {WIDTH{1'b0}} : r_regs[ra1];
   assign w_rf_b   = (ra2 == {REGBITS{1'b0}}) ? {WIDTH{1'b0}} : r_regs[ra2];
   assign w_new_wr = regwrite && (alucont != OP_CMP) && (wa != {REGBITS{1'b0}});
`else
   assign w_rf_a   = r_regs[ra1];
   assign w_rf_b   = r_regs[ra2];
   assign w_new_wr = regwrite && (alucont != OP_CMP);
`endif

   // Operand selection: the youngest in-flight producer wins over the array.
   always_comb begin
      w_opnd_a = w_rf_a;
      w_opnd_b = w_rf_b;
      if (r_s1_valid && r_s1_wr && (r_s1_wa == ra1)) begin
         w_opnd_a = w_alu_res;
      end else if (r_s2_valid && r_s2_wr && (r_s2_wa == ra1)) begin
         w_opnd_a = r_s2_result;
      end else begin
         w_opnd_a = w_rf_a;
      end
      if (use_imm) begin
         w_opnd_b = imm;
      end else if (r_s1_valid && r_s1_wr && (r_s1_wa == ra2)) begin
         w_opnd_b = w_alu_res;
      end else if (r_s2_valid && r_s2_wr && (r_s2_wa == ra2)) begin
         w_opnd_b = r_s2_result;
      end else begin
         w_opnd_b = w_rf_b;
      end
   end

   // Extra top bit carries the unsigned carry (ADD) or borrow (SUB/CMP).
   assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
   assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};

   // ALU: result and pending flags {C, L, F, Z, N} for the operation in S1.
   always_comb begin
      logic c_v, l_v, f_v, n_v;
      w_alu_res = {WIDTH{1'b0}};
      c_v = 1'b0;
      l_v = 1'b0;
      f_v = 1'b0;
      n_v = 1'b0;
      case (r_s1_op)
         OP_ADD: begin
            w_alu_res = w_sum[WIDTH-1:0];
            c_v = w_sum[WIDTH];
            f_v = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            w_alu_res = w_diff[WIDTH-1:0];
            c_v = w_diff[WIDTH];
            l_v = w_diff[WIDTH];
            f_v = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                  (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
         end
         OP_AND:  w_alu_res = r_s1_a & r_s1_b;
         OP_OR:   w_alu_res = r_s1_a | r_s1_b;
         OP_XOR:  w_alu_res = r_s1_a ^ r_s1_b;
         OP_NOT:  w_alu_res = ~r_s1_a;
         OP_LSH:  w_alu_res = r_s1_a << r_s1_b[3:0];
         OP_RSH:  w_alu_res = r_s1_a >> r_s1_b[3:0];
         default: w_alu_res = r_s1_b;
      endcase
      // Subtractions report signed less-than in N; everything else the result MSB.
      if ((r_s1_op == OP_SUB) || (r_s1_op == OP_CMP)) begin
         n_v = $signed(r_s1_a) < $signed(r_s1_b);
      end else begin
         n_v = w_alu_res[WIDTH-1];
      end
      w_alu_flags = {c_v, l_v, f_v, (w_alu_res == {WIDTH{1'b0}}), n_v};
   end

   // Pipeline advance: S1 takes the accepted operation, S2 takes S1's ALU output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_a      <= {WIDTH{1'b0}};
         r_s1_b      <= {WIDTH{1'b0}};
         r_s1_op     <= 4'd0;
         r_s1_wa     <= {REGBITS{1'b0}};
         r_s1_wr     <= 1'b0;
         r_s1_setf   <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s2_result <= {WIDTH{1'b0}};
         r_s2_flags  <= 5'd0;
         r_s2_wa     <= {REGBITS{1'b0}};
         r_s2_wr     <= 1'b0;
         r_s2_setf   <= 1'b0;
      end else if (w_advance) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_a    <= w_opnd_a;
            r_s1_b    <= w_opnd_b;
            r_s1_op   <= alucont;
            r_s1_wa   <= wa;
            r_s1_wr   <= w_new_wr;
            r_s1_setf <= set_flags;
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_result <= w_alu_res;
            r_s2_flags  <= w_alu_flags;
            r_s2_wa     <= r_s1_wa;
            r_s2_wr     <= r_s1_wr;
            r_s2_setf   <= r_s1_setf;
         end
      end
   end

   // Writeback of the register array and PSR when the consumer takes the result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= {WIDTH{1'b0}};
         end
         r_psr <= 5'd0;
      end else if (w_out_hs) begin
         if (r_s2_wr) begin
            r_regs[r_s2_wa] <= r_s2_result;
         end
         if (r_s2_setf) begin
            r_psr <= r_s2_flags;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Testbench for pipelined_datapath: directed scenarios plus randomized traffic.
// Expected results come from an architectural model (sequential register file
// and PSR updated in issue order) and are queued at accept time; a monitor
// pops and compares on every output handshake.

module tb_pipelined_datapath;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  alucont = 4'd0;
   logic [4:0]  ra1 = 5'd0;
   logic [4:0]  ra2 = 5'd0;
   logic [4:0]  wa = 5'd0;
   logic [15:0] imm = 16'h0000;
   logic        use_imm = 1'b0;
   logic        regwrite = 1'b0;
   logic        set_flags = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic [4:0]  psr_flags;

   pipelined_datapath #(.WIDTH(16), .REGBITS(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alucont(alucont), .ra1(ra1), .ra2(ra2), .wa(wa),
      .imm(imm), .use_imm(use_imm), .regwrite(regwrite), .set_flags(set_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .psr_flags(psr_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic [4:0]  psr;
   } exp_t;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   exp_t        sbq[$];
   logic [15:0] seen_res[$];
   int          seen_cyc[$];
   logic [15:0] mregs [32];
   logic [4:0]  mpsr = 5'd0;
   bit          psr_pend = 1'b0;
   logic [4:0]  psr_want = 5'd0;
   bit          rand_rdy = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mread(input logic [4:0] r);
`ifdef ZERO_REG_EN
      if (r == 5'd0) return 16'h0000;
`endif
      return mregs[r];
   endfunction

   function automatic void mwrite(input logic [4:0] r, input logic [15:0] v);
`ifdef ZERO_REG_EN
      if (r == 5'd0) return;
`endif
      mregs[r] = v;
   endfunction

   function automatic void mreset();
      for (int i = 0; i < 32; i++) mregs[i] = 16'h0000;
      mpsr = 5'd0;
   endfunction

   // Reference ALU in plain integer arithmetic.
   function automatic void alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] r, output logic [4:0] f);
      int ua, ub, sa, sb, full;
      bit c, l, v, n;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      c = 1'b0; l = 1'b0; v = 1'b0;
      case (op)
         4'd0: begin
            full = ua + ub;
            c = (full > 65535);
            v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
         end
         4'd1, 4'd9: begin
            full = ua - ub;
            c = (ua < ub);
            l = (ua < ub);
            v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
         end
         4'd2: full = ua & ub;
         4'd3: full = ua | ub;
         4'd4: full = ua ^ ub;
         4'd5: full = ~ua;
         4'd6: full = ua << (ub % 16);
         4'd7: full = ua >> (ub % 16);
         default: full = ub;
      endcase
      r = full[15:0];
      n = ((op == 4'd1) || (op == 4'd9)) ? (sa < sb) : r[15];
      f = {c, l, v, (r == 16'h0000), n};
   endfunction

   // Present one operation and hold it until accepted; update the model on accept.
   task automatic issue(input logic [3:0] op, input int a1, input int a2, input int d,
                        input logic [15:0] im, input bit ui, input bit rw, input bit sf,
                        output int waits);
      logic [15:0] a, b, r;
      logic [4:0]  f;
      in_valid = 1'b1; alucont = op;
      ra1 = 5'(a1); ra2 = 5'(a2); wa = 5'(d);
      imm = im; use_imm = ui; regwrite = rw; set_flags = sf;
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 100) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", op, waits);
      end else begin
         a = mread(5'(a1));
         b = ui ? im : mread(5'(a2));
         alu_model(op, a, b, r, f);
         if (rw && op != 4'd9) mwrite(5'(d), r);
         if (sf) mpsr = f;
         sbq.push_back('{r, mpsr});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Let every queued result leave the pipeline, bounded.
   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      @(negedge clk);
      while ((sbq.size() != 0 || out_valid) && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (sbq.size() != 0 || out_valid) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d results still pending", sbq.size());
      end
      @(posedge clk); #1;
   endtask

   // Monitor: compare every presented result and the PSR that follows its writeback.
   always @(negedge clk) begin
      if (reset_n) begin
         if (psr_pend) begin
            check("psr_after_wb", 32'(psr_flags), 32'(psr_want));
            psr_pend = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_output: got %0h with empty scoreboard", result);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("result", 32'(result), 32'(e.res));
               psr_pend = 1'b1;
               psr_want = e.psr;
               seen_res.push_back(result);
               seen_cyc.push_back(cyc);
            end
         end
      end
   end

   // Random backpressure during the randomized phase.
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      int w0, w1, base, nw;
      mreset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_psr", 32'(psr_flags), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Back-to-back dependent pair, no stall.
      out_ready = 1'b1;
      seen_res.delete(); seen_cyc.delete();
      issue(4'd8, 0, 0, 1, 16'h0005, 1'b1, 1'b1, 1'b0, w0);
      issue(4'd0, 1, 0, 2, 16'h0003, 1'b1, 1'b1, 1'b0, w1);
      drain();
      check("b2b_stall0", 32'(w0), 32'd0);
      check("b2b_stall1", 32'(w1), 32'd0);
      check("b2b_count", 32'(seen_res.size()), 32'd2);
      if (seen_res.size() == 2) begin
         check("b2b_first", 32'(seen_res[0]), 32'h0005);
         check("b2b_second", 32'(seen_res[1]), 32'h0008);
         check("b2b_gap", 32'(seen_cyc[1] - seen_cyc[0]), 32'd1);
      end

      // Signed overflow on ADD, then CMP flags with no register write.
      issue(4'd8, 0, 0, 4, 16'h7FFF, 1'b1, 1'b1, 1'b0, nw);
      issue(4'd0, 4, 0, 5, 16'h0001, 1'b1, 1'b1, 1'b1, nw);
      drain();
      check("ovf_result", 32'(seen_res[$]), 32'h8000);
      check("ovf_psr", 32'(psr_flags), 32'(5'b00101));
      issue(4'd8, 0, 0, 6, 16'h0001, 1'b1, 1'b1, 1'b0, nw);
      issue(4'd9, 6, 0, 7, 16'h0002, 1'b1, 1'b1, 1'b1, nw);
      issue(4'd8, 0, 7, 8, 16'h0000, 1'b0, 1'b1, 1'b0, nw);
      drain();
      check("cmp_result", 32'(seen_res[$-1]), 32'hFFFF);
      check("cmp_psr", 32'(psr_flags), 32'(5'b11001));
      check("cmp_no_write", 32'(seen_res[$]), 32'h0000);

      // Backpressure: three operations offered while the consumer stalls.
      base = seen_res.size();
      out_ready = 1'b0;
      fork
         begin
            issue(4'd8, 0, 0, 9, 16'h0011, 1'b1, 1'b1, 1'b0, nw);
            issue(4'd0, 9, 0, 9, 16'h0022, 1'b1, 1'b1, 1'b0, nw);
            issue(4'd0, 9, 9, 10, 16'h0000, 1'b0, 1'b1, 1'b0, nw);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_head", 32'(result), 32'h0011);
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 32'(seen_res.size() - base), 32'd3);
      if (seen_res.size() == base + 3) begin
         check("bp_order0", 32'(seen_res[base]), 32'h0011);
         check("bp_order1", 32'(seen_res[base + 1]), 32'h0033);
         check("bp_order2", 32'(seen_res[base + 2]), 32'h0066);
      end

      // Reset with two operations in flight.
      out_ready = 1'b0;
      issue(4'd8, 0, 0, 11, 16'h80AA, 1'b1, 1'b1, 1'b1, nw);
      issue(4'd8, 0, 0, 12, 16'h0055, 1'b1, 1'b1, 1'b1, nw);
      reset_n = 1'b0;
      sbq.delete();
      psr_pend = 1'b0;
      mreset();
      #2;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_psr", 32'(psr_flags), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      issue(4'd0, 11, 12, 13, 16'h0000, 1'b0, 1'b1, 1'b0, nw);
      drain();
      check("midrst_regs_zero", 32'(seen_res[$]), 32'h0000);
      check("midrst_psr_after", 32'(psr_flags), 32'd0);

      // Register 0 behaviour.
      issue(4'd8, 0, 0, 0, 16'h1234, 1'b1, 1'b1, 1'b0, nw);
      issue(4'd0, 0, 0, 3, 16'h0001, 1'b1, 1'b1, 1'b0, nw);
      drain();
`ifdef ZERO_REG_EN
      check("reg0_sum", 32'(seen_res[$]), 32'h0001);
`else
      check("reg0_sum", 32'(seen_res[$]), 32'h1235);
`endif

      // Randomized traffic with random backpressure and idle gaps.
      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [15:0] rimm;
         rimm = 16'($urandom());
         if ($urandom_range(0, 3) == 0) rimm = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
         issue(4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), rimm, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), nw);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end
      rand_rdy = 1'b0;
      @(posedge clk); #1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
